// File: rtl/eh2_posit_decode_if.sv
// Handshake bundle for the posit decoder: input posit side and decoded output side.
// EH2_POSIT_DEC_HIDDEN_EN widens fraction by one bit to carry the hidden bit.
interface eh2_posit_decode_if #(
  parameter int POSIT_LEN = 16,
  parameter int ES = 2,
  parameter int REGIME_BW = $clog2(POSIT_LEN) + 1,
  parameter int FRACTION_BW = POSIT_LEN - ES
);
`ifdef EH2_POSIT_DEC_HIDDEN_EN
  localparam int FRAC_W = FRACTION_BW + 1;
`else
  localparam int FRAC_W = FRACTION_BW;
`endif

  logic                 in_valid;
  logic                 in_ready;
  logic [POSIT_LEN-1:0] posit_in;
  logic                 out_valid;
  logic                 out_ready;
  logic                 sign;
  logic [REGIME_BW-1:0] regime;
  logic [ES-1:0]        exponent;
  logic [FRAC_W-1:0]    fraction;
  logic                 is_zero;
  logic                 is_nar;

  modport slave (
    input  in_valid, posit_in, out_ready,
    output in_ready, out_valid, sign, regime,
    output exponent, fraction, is_zero, is_nar
  );

  modport master (
    output in_valid, posit_in, out_ready,
    input  in_ready, out_valid, sign, regime,
    input  exponent, fraction, is_zero, is_nar
  );
endinterface

// File: rtl/eh2_posit_decode.sv
// Two-stage posit decoder: S1 takes sign/magnitude, S2 extracts regime/exp/frac.
// EH2_POSIT_DEC_HIDDEN_EN prepends the hidden bit to fraction.
module eh2_posit_decode #(
  parameter int POSIT_LEN = 16,
  parameter int ES = 2,
  parameter int REGIME_BW = $clog2(POSIT_LEN) + 1,
  parameter int FRACTION_BW = POSIT_LEN - ES
) (
  input logic clk,
  input logic rst_l,
  input logic flush,
  eh2_posit_decode_if.slave bus
);
  localparam int MW = POSIT_LEN - 1;
  localparam int TW = MW - ES;
  localparam int PAD = FRACTION_BW - TW;
`ifdef EH2_POSIT_DEC_HIDDEN_EN
  localparam int FRAC_W = FRACTION_BW + 1;
`else
  localparam int FRAC_W = FRACTION_BW;
`endif

  logic                 s1_valid;
  logic                 s1_sign;
  logic                 s1_zero;
  logic                 s1_nar;
  logic [MW-1:0]        s1_mag;

  logic                 o_valid;
  logic                 o_sign;
  logic [REGIME_BW-1:0] o_regime;
  logic [ES-1:0]        o_exp;
  logic [FRAC_W-1:0]    o_frac;
  logic                 o_zero;
  logic                 o_nar;

  logic                 s1_adv;
  logic                 accept;
  logic [MW-1:0]        mag_d;

  assign s1_adv = ~o_valid | bus.out_ready;
  assign bus.in_ready = ~flush & (~s1_valid | s1_adv);
  assign accept = bus.in_valid & bus.in_ready;
  assign mag_d = bus.posit_in[POSIT_LEN-1] ?
                 (~bus.posit_in[MW-1:0] + MW'(1)) :
                 bus.posit_in[MW-1:0];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_nar   <= 1'b0;
      s1_mag   <= '0;
    end else begin
      if (flush)       s1_valid <= 1'b0;
      else if (accept) s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;
      if (accept) begin
        s1_sign <= bus.posit_in[POSIT_LEN-1];
        s1_zero <= (bus.posit_in == '0);
        s1_nar  <= (bus.posit_in == {1'b1, {MW{1'b0}}});
        s1_mag  <= mag_d;
      end
    end
  end

  logic                 r0;
  logic                 done;
  logic [REGIME_BW-1:0] run;
  logic [REGIME_BW-1:0] shamt;
  logic [MW-1:0]        rem;
  logic                 special;
  logic [REGIME_BW-1:0] regime_d;
  logic [ES-1:0]        exp_d;
  logic [FRAC_W-1:0]    frac_d;

  assign r0 = s1_mag[MW-1];

  // Leading run length; an all-equal magnitude saturates at MW.
  always_comb begin
    run  = REGIME_BW'(MW);
    done = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!done && (s1_mag[i] != r0)) begin
        run  = REGIME_BW'(MW - 1 - i);
        done = 1'b1;
      end
    end
  end

  assign shamt = run + REGIME_BW'(1);
  assign rem = s1_mag << shamt;
  assign special = s1_zero | s1_nar;

  always_comb begin
    regime_d = r0 ? (run - REGIME_BW'(1)) : (-run);
    exp_d    = rem[MW-1 -: ES];
`ifdef EH2_POSIT_DEC_HIDDEN_EN
    frac_d   = {1'b1, rem[TW-1:0], {PAD{1'b0}}};
`else
    frac_d   = {rem[TW-1:0], {PAD{1'b0}}};
`endif
    if (special) begin
      regime_d = '0;
      exp_d    = '0;
      frac_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      o_valid  <= 1'b0;
      o_sign   <= 1'b0;
      o_regime <= '0;
      o_exp    <= '0;
      o_frac   <= '0;
      o_zero   <= 1'b0;
      o_nar    <= 1'b0;
    end else begin
      if (flush)       o_valid <= 1'b0;
      else if (s1_adv) o_valid <= s1_valid;
      if (s1_adv && s1_valid) begin
        o_sign   <= s1_sign & ~special;
        o_regime <= regime_d;
        o_exp    <= exp_d;
        o_frac   <= frac_d;
        o_zero   <= s1_zero;
        o_nar    <= s1_nar;
      end
    end
  end

  assign bus.out_valid = o_valid;
  assign bus.sign      = o_sign;
  assign bus.regime    = o_regime;
  assign bus.exponent  = o_exp;
  assign bus.fraction  = o_frac;
  assign bus.is_zero   = o_zero;
  assign bus.is_nar    = o_nar;
endmodule

// File: tb/tb_eh2_posit_decode.sv
// Scoreboard bench for eh2_posit_decode: bit-serial reference model, queue of expected decodes.
// Honours EH2_POSIT_DEC_HIDDEN_EN for the fraction width.
module tb_eh2_posit_decode;
  localparam int FB = 14;
`ifdef EH2_POSIT_DEC_HIDDEN_EN
  localparam int FW = FB + 1;
`else
  localparam int FW = FB;
`endif
  localparam int OW = 1 + 5 + 2 + FW + 2;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic flush = 1'b0;
  logic rnd_bp = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [OW-1:0] sb_q[$];
  logic [OW-1:0] got;
  logic [OW-1:0] prev_out;
  logic          prev_stall = 1'b0;

  eh2_posit_decode_if #(.POSIT_LEN(16), .ES(2)) bus ();

  eh2_posit_decode #(.POSIT_LEN(16), .ES(2)) dut (
    .clk(clk),
    .rst_l(rst_l),
    .flush(flush),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign got = {bus.sign, bus.regime, bus.exponent,
                bus.fraction, bus.is_zero, bus.is_nar};

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] model(input logic [15:0] p);
    logic [15:0] v;
    logic [4:0]  rk;
    logic [1:0]  e;
    logic [FB-1:0] fb;
    logic [FW-1:0] f;
    logic r0;
    int idx;
    int k;
    if (p == 16'h0000) return {1'b0, 5'd0, 2'd0, {FW{1'b0}}, 2'b10};
    if (p == 16'h8000) return {1'b0, 5'd0, 2'd0, {FW{1'b0}}, 2'b01};
    v = p[15] ? (~p + 16'd1) : p;
    r0 = v[14];
    k = 0;
    idx = 14;
    while (idx >= 0 && v[idx] == r0) begin
      k++;
      idx--;
    end
    rk = r0 ? 5'(k - 1) : 5'(-k);
    idx--;
    e = '0;
    for (int j = 0; j < 2; j++) begin
      e = {e[0], (idx >= 0) ? v[idx] : 1'b0};
      idx--;
    end
    fb = '0;
    for (int j = 0; j < FB; j++) begin
      fb = {fb[FB-2:0], (idx >= 0) ? v[idx] : 1'b0};
      idx--;
    end
`ifdef EH2_POSIT_DEC_HIDDEN_EN
    f = {1'b1, fb};
`else
    f = fb;
`endif
    return {p[15], rk, e, f, 2'b00};
  endfunction

  always @(negedge clk) begin
    if (!rst_l || flush) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && bus.out_valid)
        check("hold", 64'(got), 64'(prev_out));
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) check("spurious", 1, 0);
        else check("dec", 64'(got), 64'(sb_q.pop_front()));
      end
      if (bus.in_valid && bus.in_ready)
        sb_q.push_back(model(bus.posit_in));
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_out = got;
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1 bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] p);
    int n;
    bus.in_valid = 1'b1;
    bus.posit_in = p;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    step();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic drain();
    int n;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 || bus.out_valid) begin
      step();
      n++;
      if (n > 100) begin
        check("drain_timeout", 0, 1);
        break;
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.posit_in = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_data", 64'(got), 0);
    repeat (2) step();
    rst_l = 1'b1;
    step();
    check("rst_in_ready", 64'(bus.in_ready), 1);
    check("rst_out_valid2", 64'(bus.out_valid), 0);

    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.posit_in = 16'h4000;
    step();
    bus.in_valid = 1'b0;
    check("lat_edge1", 64'(bus.out_valid), 0);
    step();
    check("lat_edge2", 64'(bus.out_valid), 1);
    drain();

    send(16'h5A00);
    send(16'hC000);
    send(16'h7FFF);
    send(16'h0001);
    send(16'h0000);
    send(16'h8000);
    send(16'hFFFF);
    send(16'h8001);
    drain();

    bus.out_ready = 1'b0;
    send(16'h4000);
    send(16'h5A00);
    bus.in_valid = 1'b1;
    bus.posit_in = 16'h7FFF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 0);
      check("bp_out_valid", 64'(bus.out_valid), 1);
      check("bp_hold_4000", 64'(got), 64'(model(16'h4000)));
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_up", 64'(bus.in_ready), 1);
    check("bp_run0", 64'(bus.out_valid), 1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_run1", 64'(bus.out_valid), 1);
    step();
    @(negedge clk);
    check("bp_run2", 64'(bus.out_valid), 1);
    drain();

    bus.out_ready = 1'b0;
    send(16'h7FFF);
    send(16'h0001);
    bus.in_valid = 1'b1;
    bus.posit_in = 16'h5A00;
    bus.out_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(bus.in_ready), 0);
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 64'(bus.out_valid), 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("flush_no_stale", 64'(bus.out_valid), 0);
    end

    bus.out_ready = 1'b0;
    send(16'h5A00);
    send(16'hC000);
    bus.in_valid = 1'b0;
    #2;
    rst_l = 1'b0;
    #1;
    check("rst_mid_valid", 64'(bus.out_valid), 0);
    check("rst_mid_data", 64'(got), 0);
    repeat (2) step();
    @(negedge clk);
    rst_l = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("rst_mid_in_ready", 64'(bus.in_ready), 1);
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_no_stale", 64'(bus.out_valid), 0);
    end

    rnd_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      case ($urandom_range(0, 7))
        0:       send(16'h0000);
        1:       send(16'h8000);
        2:       send(16'(1 << $urandom_range(0, 15)));
        default: send(16'($urandom));
      endcase
    end
    rnd_bp = 1'b0;
    @(posedge clk);
    #2;
    drain();
    check("sb_empty", 64'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/eh2_posit_decode.md
Name: eh2_posit_decode

Overview:
- Two-stage pipelined posit decoder: unpacks a POSIT_LEN-bit posit into sign, signed regime, exponent and fraction fields, plus zero/NaR flags.
- It is the inverse of the EXU posit encode path and sits at the front of the posit ALU/MUL datapath, after operand read.
- Valid/ready handshake on both sides; full backpressure; flush support.

Parameters:
- POSIT_LEN, 16, posit width in bits.
- ES, 2, exponent field width.
- REGIME_BW, $clog2(POSIT_LEN)+1, signed regime width; must hold -(POSIT_LEN-1)..(POSIT_LEN-2).
- FRACTION_BW, POSIT_LEN-ES, fraction width; MSB-aligned, hidden bit excluded.

Ports:
- clk  in  1  clock, rising edge.
- rst_l  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all in-flight entries.
- in_valid  in  1  input posit valid.
- in_ready  out  1  decoder can accept this cycle.
- posit_in  in  POSIT_LEN  raw posit.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  consumer accepts the result.
- sign  out  1  posit sign bit.
- regime  out  REGIME_BW  signed regime k.
- exponent  out  ES  exponent field; truncated bits read as 0.
- fraction  out  FRACTION_BW  fraction bits, MSB-aligned, zero-padded.
- is_zero  out  1  input was all zeros.
- is_nar  out  1  input was 1 followed by all zeros.

Behaviour:
- Reset (rst_l=0, async): s1_valid=0, out_valid=0; all output data registers 0. in_ready is 1 once reset deasserts.
- S1 (on in_valid & in_ready):
  - Register sign=posit_in[MSB] and is_zero/is_nar from the raw pattern.
  - Register mag = sign ? two's complement of posit_in[POSIT_LEN-2:0] : posit_in[POSIT_LEN-2:0].
- S2 (output register, loaded when S1 advances):
  - r0 = mag[MSB]; run = count of leading bits equal to r0, saturating at POSIT_LEN-1.
  - regime = r0 ? run-1 : -run.
  - Remaining bits after the run and its terminator: the first ES bits go to exponent (LSBs zero-filled if short); the rest go MSB-aligned into fraction, zero-filled.
  - Zero/NaR: regime, exponent and fraction are forced to 0, and sign is forced to 0. (is_nar identifies NaR.)
- Latency: 2 cycles. An input accepted at edge N shows out_valid=1 after edge N+1.
- Handshake:
  - Output holds stable while out_valid & !out_ready.
  - S1 advances when !out_valid | out_ready.
  - in_ready = !s1_valid | S1 advancing (combinational).
  - Capacity is 2 entries; throughput is 1/cycle with no bubbles under continuous out_ready.
- Simultaneous events:
  - Accept and output handoff in the same cycle are both honoured.
  - in_valid with in_ready=0: posit_in is ignored; the source must hold it.
- flush: the next edge clears s1_valid and out_valid. Any input presented in the flush cycle is dropped, and in_ready is held 0 that cycle. Data registers need not clear.
- Reset mid-operation: all entries discarded immediately; no spurious out_valid after release.

Optional Feature:
- Macro: EH2_POSIT_DEC_HIDDEN_EN.
- Defined: fraction width becomes FRACTION_BW+1, with the hidden bit at the MSB (1 for normal values, 0 for zero/NaR). Stored fraction bits follow below it.
- Undefined: fraction is FRACTION_BW bits with no hidden bit.

Test Plan:
- posit_in=0x4000 -> sign=0, regime=0, exponent=0, fraction=0x0000, is_zero=0, is_nar=0; out_valid asserted 2 edges after accept.
- 0x5A00 -> sign=0, regime=0, exponent=3, fraction=0x1000; and 0xC000 -> sign=1, regime=0, exponent=0, fraction=0.
- 0x7FFF -> regime=14, exponent=0, fraction=0; 0x0001 -> regime=-14 (5'b10010), exponent=0, fraction=0.
- 0x0000 -> is_zero=1, all fields 0; 0x8000 -> is_nar=1, sign=0, all fields 0.
- Backpressure:
  - Stimulus: stream 0x4000, 0x5A00, 0x7FFF with out_ready=0.
  - Required: first two accepted; in_ready=0 on the third; output holds 0x4000 decode.
  - Then raise out_ready: three results appear in order on consecutive cycles.
- Flush/reset:
  - Stimulus: two entries in flight, assert flush one cycle.
  - Required: out_valid=0 next cycle and no stale result afterward.
  - Repeat with rst_l pulsed low mid-stream: outputs 0 immediately.
